// File: rtl/metroid_enemy_ctrl.sv
// metroid_enemy_ctrl: per-enemy patrol/hurt/dead controller driving sprite
// position and visibility. All outputs are registered.
// Optional build macro ENEMY_FLASH_EN: when defined, the sprite blinks during
// HURT using bit 1 of the hurt counter; otherwise it stays visible.
module metroid_enemy_ctrl #(
  parameter logic [9:0] X_MIN       = 10'd64,
  parameter logic [9:0] X_MAX       = 10'd560,
  parameter logic [9:0] Y_POS       = 10'd400,
  parameter logic [3:0] STEP        = 4'd2,
  parameter logic [1:0] HP_INIT     = 2'd3,
  parameter logic [4:0] HURT_FRAMES = 5'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_in,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [9:0] enemy_x,
  output logic [9:0] enemy_y,
  output logic       enemy_on,
  output logic       enemy_dir,
  output logic       enemy_alive,
  output logic [1:0] enemy_hp
);

  typedef enum logic [1:0] {
    S_OFF,
    S_PATROL,
    S_HURT,
    S_DEAD
  } state_t;

  state_t      r_state;
  logic [4:0]  r_hurt_cnt;

  logic [10:0] w_x_inc;
  logic [9:0]  w_x_dec;
  logic        w_right_bound;
  logic        w_left_bound;
  logic [4:0]  w_cnt_dec;
  logic        w_hurt_on_load;
  logic        w_hurt_on_dec;

  // 11-bit position arithmetic so the right-bound compare never wraps
  assign w_x_inc       = {1'b0, enemy_x} + {7'd0, STEP};
  assign w_x_dec       = enemy_x - {6'd0, STEP};
  assign w_right_bound = (w_x_inc >= {1'b0, X_MAX});
  assign w_left_bound  = ({1'b0, enemy_x} <= ({1'b0, X_MIN} + {7'd0, STEP}));
  assign w_cnt_dec     = r_hurt_cnt - 5'd1;

`ifdef ENEMY_FLASH_EN
  // visibility follows bit 1 of the counter value being registered this edge
  assign w_hurt_on_load = HURT_FRAMES[1];
  assign w_hurt_on_dec  = w_cnt_dec[1];
`else
  assign w_hurt_on_load = 1'b1;
  assign w_hurt_on_dec  = 1'b1;
`endif

  // state machine with registered sprite outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_OFF;
      r_hurt_cnt  <= '0;
      enemy_x     <= X_MIN;
      enemy_y     <= Y_POS;
      enemy_on    <= 1'b0;
      enemy_dir   <= 1'b0;
      enemy_alive <= 1'b0;
      enemy_hp    <= HP_INIT;
    end else if (!enable_in) begin
      // disable wins over hit and tick; position and hp freeze
      r_state     <= S_OFF;
      enemy_on    <= 1'b0;
      enemy_alive <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_state     <= S_PATROL;
          enemy_x     <= X_MIN;
          enemy_dir   <= 1'b0;
          enemy_hp    <= HP_INIT;
          enemy_on    <= 1'b1;
          enemy_alive <= 1'b1;
        end
        S_PATROL: begin
          if (hit) begin
            if (enemy_hp <= 2'd1) begin
              r_state     <= S_DEAD;
              enemy_hp    <= '0;
              enemy_on    <= 1'b0;
              enemy_alive <= 1'b0;
            end else begin
              r_state    <= S_HURT;
              enemy_hp   <= enemy_hp - 2'd1;
              r_hurt_cnt <= HURT_FRAMES;
              enemy_on   <= w_hurt_on_load;
            end
          end else if (frame_tick) begin
            if (!enemy_dir) begin
              if (w_right_bound) begin
                enemy_x   <= X_MAX;
                enemy_dir <= 1'b1;
              end else begin
                enemy_x <= w_x_inc[9:0];
              end
            end else begin
              if (w_left_bound) begin
                enemy_x   <= X_MIN;
                enemy_dir <= 1'b0;
              end else begin
                enemy_x <= w_x_dec;
              end
            end
          end
        end
        S_HURT: begin
          if (frame_tick) begin
            r_hurt_cnt <= w_cnt_dec;
            if (r_hurt_cnt <= 5'd1) begin
              r_state  <= S_PATROL;
              enemy_on <= 1'b1;
            end else begin
              enemy_on <= w_hurt_on_dec;
            end
          end
        end
        S_DEAD: begin
          r_state <= S_DEAD;
        end
        default: begin
          r_state <= S_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_metroid_enemy_ctrl.sv
// tb_metroid_enemy_ctrl: scenario tasks plus randomized run against a
// behavioural model of the enemy controller. Honours ENEMY_FLASH_EN.
module tb_metroid_enemy_ctrl;

  localparam int XMIN  = 64;
  localparam int XMAX  = 560;
  localparam int YPOS  = 400;
  localparam int STP   = 2;
  localparam int HPI   = 3;
  localparam int HURTF = 16;

  logic       clk;
  logic       reset;
  logic       enable_in;
  logic       frame_tick;
  logic       hit;
  logic [9:0] enemy_x;
  logic [9:0] enemy_y;
  logic       enemy_on;
  logic       enemy_dir;
  logic       enemy_alive;
  logic [1:0] enemy_hp;

  int checks = 0;
  int errors = 0;

  metroid_enemy_ctrl #(
    .X_MIN      (10'd64),
    .X_MAX      (10'd560),
    .Y_POS      (10'd400),
    .STEP       (4'd2),
    .HP_INIT    (2'd3),
    .HURT_FRAMES(5'd16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_in  (enable_in),
    .frame_tick (frame_tick),
    .hit        (hit),
    .enemy_x    (enemy_x),
    .enemy_y    (enemy_y),
    .enemy_on   (enemy_on),
    .enemy_dir  (enemy_dir),
    .enemy_alive(enemy_alive),
    .enemy_hp   (enemy_hp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model
  typedef enum int {M_OFF, M_PATROL, M_HURT, M_DEAD} mode_t;
  mode_t m_mode = M_OFF;
  int    m_x    = XMIN;
  int    m_dir  = 0;
  int    m_hp   = HPI;
  int    m_left = 0;

  function automatic bit exp_on();
    if (m_mode == M_PATROL) return 1'b1;
    if (m_mode == M_HURT) begin
`ifdef ENEMY_FLASH_EN
      return ((m_left / 2) % 2) == 1;
`else
      return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic bit exp_alive();
    return (m_mode == M_PATROL) || (m_mode == M_HURT);
  endfunction

  task automatic model_step(input bit r, input bit en, input bit tk, input bit h);
    if (r) begin
      m_mode = M_OFF; m_x = XMIN; m_dir = 0; m_hp = HPI; m_left = 0;
    end else if (!en) begin
      m_mode = M_OFF;
    end else begin
      case (m_mode)
        M_OFF: begin
          m_mode = M_PATROL; m_x = XMIN; m_dir = 0; m_hp = HPI;
        end
        M_PATROL: begin
          if (h) begin
            if (m_hp <= 1) begin m_hp = 0; m_mode = M_DEAD; end
            else begin m_hp = m_hp - 1; m_left = HURTF; m_mode = M_HURT; end
          end else if (tk) begin
            if (m_dir == 0) begin
              if (m_x + STP >= XMAX) begin m_x = XMAX; m_dir = 1; end
              else m_x = m_x + STP;
            end else begin
              if (m_x - STP <= XMIN) begin m_x = XMIN; m_dir = 0; end
              else m_x = m_x - STP;
            end
          end
        end
        M_HURT: begin
          if (tk) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_PATROL;
          end
        end
        default: ;
      endcase
    end
  endtask

  // drive on falling edge, update model on rising edge, settle 1 time unit
  task automatic step(input bit r, input bit en, input bit tk, input bit h);
    @(negedge clk);
    reset = r; enable_in = en; frame_tick = tk; hit = h;
    @(posedge clk);
    model_step(r, en, tk, h);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    checks++;
    if (enemy_x !== 10'd64 || enemy_y !== 10'd400 || enemy_on !== 1'b0 ||
        enemy_dir !== 1'b0 || enemy_alive !== 1'b0 || enemy_hp !== 2'd3) begin
      errors++;
      $display("FAIL reset: x=%0d y=%0d on=%0b dir=%0b alive=%0b hp=%0d exp 64 400 0 0 0 3",
               enemy_x, enemy_y, enemy_on, enemy_dir, enemy_alive, enemy_hp);
    end
  endtask

  task automatic test_enable();
    step(0, 1, 0, 0);
    checks++;
    if (enemy_on !== 1'b1 || enemy_alive !== 1'b1 || enemy_x !== 10'd64 ||
        enemy_hp !== 2'd3 || enemy_dir !== 1'b0) begin
      errors++;
      $display("FAIL enable: on=%0b alive=%0b x=%0d hp=%0d dir=%0b exp 1 1 64 3 0",
               enemy_on, enemy_alive, enemy_x, enemy_hp, enemy_dir);
    end
  endtask

  task automatic test_patrol_bounds();
    for (int i = 0; i < 247; i++) begin
      step(0, 1, 1, 0);
      checks++;
      if (enemy_x !== 10'(m_x) || enemy_dir !== 1'(m_dir)) begin
        errors++;
        $display("FAIL patrol_walk: x=%0d dir=%0b exp %0d %0d", enemy_x, enemy_dir, m_x, m_dir);
      end
    end
    step(0, 1, 1, 0);
    checks++;
    if (enemy_x !== 10'd560 || enemy_dir !== 1'b1) begin
      errors++;
      $display("FAIL right_bound: x=%0d dir=%0b exp 560 1", enemy_x, enemy_dir);
    end
    step(0, 1, 1, 0);
    checks++;
    if (enemy_x !== 10'd558) begin
      errors++;
      $display("FAIL right_turn: x=%0d exp 558", enemy_x);
    end
    for (int i = 0; i < 246; i++) step(0, 1, 1, 0);
    checks++;
    if (enemy_x !== 10'd66 || enemy_dir !== 1'b1) begin
      errors++;
      $display("FAIL walk_left: x=%0d dir=%0b exp 66 1", enemy_x, enemy_dir);
    end
    step(0, 1, 1, 0);
    checks++;
    if (enemy_x !== 10'd64 || enemy_dir !== 1'b0) begin
      errors++;
      $display("FAIL left_bound: x=%0d dir=%0b exp 64 0", enemy_x, enemy_dir);
    end
    step(0, 1, 1, 0);
    checks++;
    if (enemy_x !== 10'd66) begin
      errors++;
      $display("FAIL left_turn: x=%0d exp 66", enemy_x);
    end
  endtask

  task automatic test_hit_tick();
    for (int i = 0; i < 17; i++) step(0, 1, 1, 0);
    checks++;
    if (enemy_x !== 10'd100) begin
      errors++;
      $display("FAIL reach_100: x=%0d exp 100", enemy_x);
    end
    step(0, 1, 1, 1);
    checks++;
    if (enemy_x !== 10'd100 || enemy_hp !== 2'd2 || enemy_alive !== 1'b1 || enemy_on !== exp_on()) begin
      errors++;
      $display("FAIL hit_tick: x=%0d hp=%0d alive=%0b on=%0b exp 100 2 1 %0b",
               enemy_x, enemy_hp, enemy_alive, enemy_on, exp_on());
    end
    for (int i = 0; i < 15; i++) begin
      // idle cycles and a stray hit must not advance or re-hit
      if (i == 4) step(0, 1, 0, 1);
      if (i == 7) step(0, 1, 0, 0);
      step(0, 1, 1, (i == 9));
      checks++;
      if (enemy_x !== 10'd100 || enemy_hp !== 2'd2 || enemy_alive !== 1'b1 || enemy_on !== exp_on()) begin
        errors++;
        $display("FAIL hurt_hold: tick=%0d x=%0d hp=%0d alive=%0b on=%0b exp 100 2 1 %0b",
                 i + 1, enemy_x, enemy_hp, enemy_alive, enemy_on, exp_on());
      end
    end
    step(0, 1, 1, 0);
    checks++;
    if (enemy_x !== 10'd100 || enemy_on !== 1'b1 || enemy_alive !== 1'b1) begin
      errors++;
      $display("FAIL hurt_expire: x=%0d on=%0b alive=%0b exp 100 1 1", enemy_x, enemy_on, enemy_alive);
    end
    step(0, 1, 1, 0);
    checks++;
    if (enemy_x !== 10'd102) begin
      errors++;
      $display("FAIL resume_move: x=%0d exp 102", enemy_x);
    end
  endtask

  task automatic test_death_respawn();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int h = 0; h < 3; h++) begin
      step(0, 1, 0, 1);
      if (h < 2) for (int t = 0; t < HURTF; t++) step(0, 1, 1, 0);
    end
    checks++;
    if (enemy_hp !== 2'd0 || enemy_on !== 1'b0 || enemy_alive !== 1'b0) begin
      errors++;
      $display("FAIL dead: hp=%0d on=%0b alive=%0b exp 0 0 0", enemy_hp, enemy_on, enemy_alive);
    end
    for (int i = 0; i < 6; i++) step(0, 1, i % 2, i % 3 == 0);
    checks++;
    if (enemy_hp !== 2'd0 || enemy_on !== 1'b0 || enemy_alive !== 1'b0) begin
      errors++;
      $display("FAIL dead_hold: hp=%0d on=%0b alive=%0b exp 0 0 0", enemy_hp, enemy_on, enemy_alive);
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (enemy_hp !== 2'd3 || enemy_x !== 10'd64 || enemy_on !== 1'b1 || enemy_alive !== 1'b1) begin
      errors++;
      $display("FAIL respawn: hp=%0d x=%0d on=%0b alive=%0b exp 3 64 1 1",
               enemy_hp, enemy_x, enemy_on, enemy_alive);
    end
  endtask

  task automatic test_disable_in_hurt();
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    checks++;
    if (enemy_on !== 1'b0 || enemy_alive !== 1'b0 || enemy_hp !== 2'd2 || enemy_x !== 10'd74) begin
      errors++;
      $display("FAIL disable_hurt: on=%0b alive=%0b hp=%0d x=%0d exp 0 0 2 74",
               enemy_on, enemy_alive, enemy_hp, enemy_x);
    end
  endtask

  task automatic test_reset_with_hit();
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    step(1, 1, 0, 1);
    checks++;
    if (enemy_hp !== 2'd3 || enemy_x !== 10'd64 || enemy_on !== 1'b0 ||
        enemy_alive !== 1'b0 || enemy_dir !== 1'b0 || enemy_y !== 10'd400) begin
      errors++;
      $display("FAIL reset_hit: hp=%0d x=%0d on=%0b alive=%0b dir=%0b y=%0d exp 3 64 0 0 0 400",
               enemy_hp, enemy_x, enemy_on, enemy_alive, enemy_dir, enemy_y);
    end
  endtask

  task automatic test_random();
    bit r, en, tk, h;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 599) == 0);
      en = ($urandom_range(0, 99) >= 2);
      tk = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 29) == 0);
      step(r, en, tk, h);
      checks++;
      if (enemy_x !== 10'(m_x) || enemy_y !== 10'(YPOS) || enemy_dir !== 1'(m_dir) ||
          enemy_hp !== 2'(m_hp) || enemy_on !== exp_on() || enemy_alive !== exp_alive()) begin
        errors++;
        $display("FAIL random[%0d]: x=%0d y=%0d dir=%0b hp=%0d on=%0b alive=%0b exp %0d %0d %0d %0d %0b %0b",
                 i, enemy_x, enemy_y, enemy_dir, enemy_hp, enemy_on, enemy_alive,
                 m_x, YPOS, m_dir, m_hp, exp_on(), exp_alive());
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable_in = 1'b0; frame_tick = 1'b0; hit = 1'b0;
    test_reset();
    test_enable();
    test_patrol_bounds();
    test_hit_tick();
    test_death_respawn();
    test_disable_in_hurt();
    test_reset_with_hit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
